// File: rtl/pipe_addsub_unit_if.sv
// Operand/result handshake bundle for pipe_addsub_unit.
// master drives operands and out_ready; slave is the arithmetic pipeline.
interface pipe_addsub_unit_if #(
    parameter int W      = 20,
    parameter int STAGES = 2,
    parameter int TAG_W  = 4
) ();
    localparam int OCC_W = $clog2(STAGES + 1);

    logic               in_valid;
    logic               in_ready;
    logic [W-1:0]       a;
    logic [W-1:0]       b;
    logic [1:0]         mode;
    logic [TAG_W-1:0]   tag_in;

    logic               out_valid;
    logic               out_ready;
    logic [W-1:0]       y;
    logic               flag;
    logic [TAG_W-1:0]   tag_out;
    logic [OCC_W-1:0]   occupancy;

    modport master (
        output in_valid, a, b, mode, tag_in, out_ready,
        input  in_ready, out_valid, y, flag, tag_out, occupancy
    );

    modport slave (
        input  in_valid, a, b, mode, tag_in, out_ready,
        output in_ready, out_valid, y, flag, tag_out, occupancy
    );
endinterface

// File: rtl/pipe_addsub_unit.sv
// Pipelined add / add+1 / subtract / saturating-add unit with carry/borrow/sat flag and tag passthrough.
// Latency STAGES cycles from accept to result register; one beat per cycle when unstalled.
// Backpressure: stages advance into empty or draining slots, so bubbles collapse and in_ready drops only when full and stalled.
module pipe_addsub_unit #(
    parameter int W      = 20,
    parameter int STAGES = 2,
    parameter int TAG_W  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    pipe_addsub_unit_if.slave  bus
);
    localparam int OCC_W = $clog2(STAGES + 1);

    typedef struct packed {
        logic [W-1:0]     res;
        logic             flg;
        logic [TAG_W-1:0] tg;
    } stage_t;

    stage_t            st [STAGES];
    logic [STAGES-1:0] vld;
    logic [STAGES-1:0] adv;
    logic [OCC_W-1:0]  occ;

    logic [W:0] sum;
    logic [W:0] diff;
    stage_t     comp;
    logic       accept;
    logic       deliver;

    always_comb begin
        sum      = {1'b0, bus.a} + {1'b0, bus.b} + {{W{1'b0}}, (bus.mode == 2'b01)};
        diff     = {1'b0, bus.a} - {1'b0, bus.b};
        comp.tg  = bus.tag_in;
        comp.res = sum[W-1:0];
        comp.flg = sum[W];
        case (bus.mode)
            2'b10: begin
                // Top bit of the W+1-bit difference is the borrow, i.e. a < b.
                comp.res = diff[W-1:0];
                comp.flg = diff[W];
            end
            2'b11: begin
                if (sum[W]) begin
                    comp.res = '1;
                    comp.flg = 1'b1;
                end else begin
                    comp.res = sum[W-1:0];
                    comp.flg = 1'b0;
                end
            end
            default: begin
                comp.res = sum[W-1:0];
                comp.flg = sum[W];
            end
        endcase
    end

    // Stage k may load iff some stage at or after k is empty or the consumer is taking the last one.
    for (genvar k = 0; k < STAGES; k++) begin : g_adv
        assign adv[k] = bus.out_ready | ~(&vld[STAGES-1:k]);
    end

    assign accept  = bus.in_valid & adv[0];
    assign deliver = vld[STAGES-1] & bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
            occ <= '0;
            for (int k = 0; k < STAGES; k++) begin
                st[k] <= '0;
            end
        end else begin
            if (adv[0]) begin
                vld[0] <= bus.in_valid;
                if (bus.in_valid) begin
                    st[0] <= comp;
                end
            end
            // Payload only moves with a valid beat so idle outputs keep the last result.
            for (int k = 1; k < STAGES; k++) begin
                if (adv[k]) begin
                    vld[k] <= vld[k-1];
                    if (vld[k-1]) begin
                        st[k] <= st[k-1];
                    end
                end
            end
            case ({accept, deliver})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    assign bus.in_ready  = adv[0];
    assign bus.out_valid = vld[STAGES-1];
    assign bus.y         = st[STAGES-1].res;
    assign bus.flag      = st[STAGES-1].flg;
    assign bus.tag_out   = st[STAGES-1].tg;
    assign bus.occupancy = occ;
endmodule
